// File: rtl/rx_block_sync.sv
// 64b/66b receive block synchronizer with self-synchronizing descrambler (1 + x^39 + x^58).
// Hunts sync-header alignment via gearbox slips and forwards descrambled blocks only while locked.
module rx_block_sync #(
  parameter int PCS_DATA_WIDTH = 66,
  parameter int LOCK_CNT       = 64,
  parameter int BAD_SH_MAX     = 16,
  parameter int SLIP_WAIT      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PCS_DATA_WIDTH-1:0] rx_data_in,
  input  logic                      rx_valid_in,
  output logic [PCS_DATA_WIDTH-1:0] encoded_data_out,
  output logic                      encoded_valid_out,
  output logic                      slip_out,
  output logic                      block_lock
);

  localparam int PW     = PCS_DATA_WIDTH - 2;
  localparam int SH_W   = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(BAD_SH_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(LOCK_CNT - 1);
  localparam logic [SH_W-1:0]   SH_ONE    = SH_W'(1);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(BAD_SH_MAX - 1);
  localparam logic [BAD_W-1:0]  BAD_ONE   = BAD_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  typedef enum logic [1:0] {
    ST_RESET_CNT,
    ST_TEST_SH,
    ST_SLIP,
    ST_SLIP_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [SH_W-1:0]     sh_cnt_q, sh_cnt_d;
  logic [BAD_W-1:0]    bad_cnt_q, bad_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                block_lock_q, block_lock_d;
  logic                slip_q, slip_d;
  logic [57:0]         scr_q, scr_d;
  logic [PCS_DATA_WIDTH-1:0] enc_data_q, enc_data_d;
  logic                enc_valid_q, enc_valid_d;

  logic                hdr_ok;
  logic [PW+57:0]      desc_x;
  logic [PW-1:0]       plain;

  assign hdr_ok = rx_data_in[PCS_DATA_WIDTH-1] ^ rx_data_in[PCS_DATA_WIDTH-2];

  // Descrambled bit i depends on the received bits 39 and 58 positions earlier in wire order.
  always_comb begin
    desc_x = {rx_data_in[PW-1:0], scr_q};
    plain  = '0;
    for (int i = 0; i < PW; i++) begin
      plain[i] = desc_x[58+i] ^ desc_x[19+i] ^ desc_x[i];
    end
  end

  always_comb begin
    state_d      = state_q;
    sh_cnt_d     = sh_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    wait_cnt_d   = wait_cnt_q;
    block_lock_d = block_lock_q;
    slip_d       = 1'b0;
    case (state_q)
      ST_RESET_CNT: begin
        sh_cnt_d   = '0;
        bad_cnt_d  = '0;
        wait_cnt_d = '0;
        state_d    = ST_TEST_SH;
      end
      ST_TEST_SH: begin
        if (rx_valid_in) begin
          if (!block_lock_q) begin
            if (!hdr_ok) begin
              slip_d  = 1'b1;
              state_d = ST_SLIP;
            end else if (sh_cnt_q == SH_LAST) begin
              block_lock_d = 1'b1;
              state_d      = ST_RESET_CNT;
            end else begin
              sh_cnt_d = sh_cnt_q + SH_ONE;
            end
          end else begin
            sh_cnt_d = sh_cnt_q + SH_ONE;
            if (!hdr_ok) begin
              bad_cnt_d = bad_cnt_q + BAD_ONE;
            end
            // Too many bad headers beats a clean window end in the same cycle.
            if (!hdr_ok && bad_cnt_q == BAD_LAST) begin
              block_lock_d = 1'b0;
              slip_d       = 1'b1;
              state_d      = ST_SLIP;
            end else if (sh_cnt_q == SH_LAST) begin
              state_d = ST_RESET_CNT;
            end
          end
        end
      end
      ST_SLIP: begin
        block_lock_d = 1'b0;
        wait_cnt_d   = '0;
        state_d      = ST_SLIP_WAIT;
      end
      ST_SLIP_WAIT: begin
        if (rx_valid_in) begin
          if (wait_cnt_q == WAIT_LAST) begin
            state_d = ST_RESET_CNT;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_ONE;
          end
        end
      end
      default: state_d = ST_RESET_CNT;
    endcase
  end

  always_comb begin
    enc_valid_d = rx_valid_in & block_lock_q;
    enc_data_d  = enc_valid_d ? {rx_data_in[PCS_DATA_WIDTH-1:PW], plain} : enc_data_q;
    scr_d       = rx_valid_in ? rx_data_in[PW-1:PW-58] : scr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_RESET_CNT;
      sh_cnt_q     <= '0;
      bad_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      block_lock_q <= 1'b0;
      slip_q       <= 1'b0;
      scr_q        <= '0;
      enc_data_q   <= '0;
      enc_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_cnt_q     <= sh_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      block_lock_q <= block_lock_d;
      slip_q       <= slip_d;
      scr_q        <= scr_d;
      enc_data_q   <= enc_data_d;
      enc_valid_q  <= enc_valid_d;
    end
  end

  assign encoded_data_out  = enc_data_q;
  assign encoded_valid_out = enc_valid_q;
  assign slip_out          = slip_q;
  assign block_lock        = block_lock_q;

endmodule

// File: tb/tb_rx_block_sync.sv
// Bench for rx_block_sync: scrambles known payloads, queues the expected forwarded blocks and
// pops them as the synchronizer emits them, alongside lock/slip timing checks per scenario.
`timescale 1ns/1ps
module tb_rx_block_sync;

  localparam logic [57:0] SEED = 58'h3FF_FFFF_FFFF_FFFF;
  localparam logic [63:0] IDLE = 64'h1E00_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [65:0] rx_data_in = '0;
  logic        rx_valid_in = 1'b0;
  logic [65:0] encoded_data_out;
  logic        encoded_valid_out;
  logic        slip_out;
  logic        block_lock;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [57:0] scr_st = SEED;
  logic        exp_lock = 1'b0;
  logic        exp_fwd = 1'b0;
  logic [65:0] exp_q[$];
  logic [65:0] last_fwd = '0;
  logic [65:0] exp_blk;

  rx_block_sync dut (
    .clk               (clk),
    .rst               (rst),
    .rx_data_in        (rx_data_in),
    .rx_valid_in       (rx_valid_in),
    .encoded_data_out  (encoded_data_out),
    .encoded_valid_out (encoded_valid_out),
    .slip_out          (slip_out),
    .block_lock        (block_lock)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Transmit-side scrambler: y[i] = d[i] ^ y[i-39] ^ y[i-58].
  function automatic logic [63:0] scramble(input logic [63:0] d, input logic [57:0] st);
    logic [121:0] x;
    x = '0;
    x[57:0] = st;
    for (int i = 0; i < 64; i++) x[58+i] = d[i] ^ x[19+i] ^ x[i];
    return x[121:58];
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic drive(input logic [1:0] hdr, input logic [63:0] plain, input logic valid);
    logic [63:0] y;
    logic [95:0] r;
    @(negedge clk);
    r = {$urandom(), $urandom(), $urandom()};
    rx_valid_in = valid;
    exp_fwd = valid && exp_lock;
    if (valid) begin
      y = scramble(plain, scr_st);
      scr_st = y[63:6];
      rx_data_in = {hdr, y};
      if (exp_fwd) exp_q.push_back({hdr, plain});
    end else begin
      rx_data_in = r[65:0];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    rx_valid_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_lock = 1'b0;
    exp_fwd = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rx_data_in = {2'b01, rand64()};
      rx_valid_in = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({encoded_data_out, encoded_valid_out, slip_out, block_lock} !== 69'd0) begin
        n_fail++;
        $display("[TB] FAIL reset_outputs: got data=%h valid=%b slip=%b lock=%b, required all 0",
                 encoded_data_out, encoded_valid_out, slip_out, block_lock);
      end
    end
    @(negedge clk);
    rx_valid_in = 1'b0;
    rst = 1'b1;
    exp_lock = 1'b0;
    exp_q.delete();
    for (int i = 1; i <= 65; i++) begin
      drive(2'b01, rand64(), 1'b1);
      @(posedge clk); #1;
      n_checks++;
      if (encoded_valid_out !== exp_fwd) begin
        n_fail++;
        $display("[TB] FAIL reset_fwd blk %0d: valid_out=%b required %b", i, encoded_valid_out, exp_fwd);
      end
      if (exp_fwd) begin
        exp_blk = exp_q.pop_front();
        last_fwd = exp_blk;
        n_checks++;
        if (encoded_data_out !== exp_blk) begin
          n_fail++;
          $display("[TB] FAIL reset_data blk %0d: got %h required %h", i, encoded_data_out, exp_blk);
        end
      end
      n_checks++;
      if (block_lock !== (i >= 64)) begin
        n_fail++;
        $display("[TB] FAIL reset_lock blk %0d: lock=%b required %b", i, block_lock, (i >= 64));
      end
      if (i == 64) exp_lock = 1'b1;
    end
  endtask

  task automatic test_descrambler();
    do_reset();
    scr_st = SEED;
    for (int i = 1; i <= 72; i++) begin
      if (i == 1) drive(2'b01, 64'h0, 1'b1);
      else        drive(2'b10, IDLE, 1'b1);
      @(posedge clk); #1;
      n_checks++;
      if (encoded_valid_out !== exp_fwd) begin
        n_fail++;
        $display("[TB] FAIL descr_fwd blk %0d: valid_out=%b required %b", i, encoded_valid_out, exp_fwd);
      end
      if (exp_fwd) begin
        exp_blk = exp_q.pop_front();
        last_fwd = exp_blk;
        n_checks++;
        if (encoded_data_out !== exp_blk || encoded_data_out !== 66'h2_1E00_0000_0000_0000) begin
          n_fail++;
          $display("[TB] FAIL descr_data blk %0d: got %h required %h", i, encoded_data_out, exp_blk);
        end
      end
      if (i == 64) begin
        n_checks++;
        if (block_lock !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL descr_lock: lock=%b required 1", block_lock);
        end
        exp_lock = 1'b1;
      end
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    drive(2'b11, rand64(), 1'b1);
    @(posedge clk); #1;
    n_checks++;
    if (slip_out !== 1'b1 || block_lock !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mis_slip: slip=%b lock=%b, required slip=1 lock=0", slip_out, block_lock);
    end
    drive(2'b01, rand64(), 1'b0);
    @(posedge clk); #1;
    n_checks++;
    if (slip_out !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mis_slip_width: slip=%b required 0", slip_out);
    end
    // 4 ignored blocks, 1 uncounted restart block, then 64 counted headers.
    for (int j = 1; j <= 69; j++) begin
      drive((j % 2) ? 2'b01 : 2'b10, rand64(), 1'b1);
      @(posedge clk); #1;
      n_checks++;
      if (encoded_valid_out !== exp_fwd || slip_out !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL mis_quiet blk %0d: valid_out=%b slip=%b, required 0 0", j, encoded_valid_out, slip_out);
      end
      n_checks++;
      if (block_lock !== (j == 69)) begin
        n_fail++;
        $display("[TB] FAIL mis_lock blk %0d: lock=%b required %b", j, block_lock, (j == 69));
      end
    end
    exp_lock = 1'b1;
  endtask

  task automatic test_tolerance();
    logic [1:0] hdr;
    do_reset();
    for (int n = 0; n < 64 + 1 + 64 + 1 + 16 + 1; n++) begin
      hdr = 2'b01;
      if (n >= 65 && n < 129 && ((n - 65) % 4 == 1) && (n - 65) < 60) hdr = (n % 2) ? 2'b00 : 2'b11;
      if (n >= 130 && n < 146) hdr = (n % 2) ? 2'b11 : 2'b00;
      drive(hdr, rand64(), 1'b1);
      @(posedge clk); #1;
      n_checks++;
      if (encoded_valid_out !== exp_fwd) begin
        n_fail++;
        $display("[TB] FAIL tol_fwd blk %0d: valid_out=%b required %b", n, encoded_valid_out, exp_fwd);
      end
      if (exp_fwd) begin
        exp_blk = exp_q.pop_front();
        last_fwd = exp_blk;
        n_checks++;
        if (encoded_data_out !== exp_blk) begin
          n_fail++;
          $display("[TB] FAIL tol_data blk %0d: got %h required %h", n, encoded_data_out, exp_blk);
        end
      end
      n_checks++;
      if (block_lock !== (n >= 63 && n < 145) || slip_out !== (n == 145)) begin
        n_fail++;
        $display("[TB] FAIL tol_lock blk %0d: lock=%b slip=%b required lock=%b slip=%b",
                 n, block_lock, slip_out, (n >= 63 && n < 145), (n == 145));
      end
      if (n == 63) exp_lock = 1'b1;
      if (n == 145) exp_lock = 1'b0;
    end
    n_checks++;
    if (encoded_data_out !== last_fwd) begin
      n_fail++;
      $display("[TB] FAIL tol_hold: data=%h required held %h", encoded_data_out, last_fwd);
    end
  endtask

  task automatic test_gapped();
    do_reset();
    for (int k = 0; k < 129; k++) begin
      drive(2'b01, rand64(), (k % 2 == 0));
      @(posedge clk); #1;
      n_checks++;
      if (encoded_valid_out !== exp_fwd) begin
        n_fail++;
        $display("[TB] FAIL gap_fwd cyc %0d: valid_out=%b required %b", k, encoded_valid_out, exp_fwd);
      end
      if (exp_fwd) begin
        exp_blk = exp_q.pop_front();
        last_fwd = exp_blk;
        n_checks++;
        if (encoded_data_out !== exp_blk) begin
          n_fail++;
          $display("[TB] FAIL gap_data cyc %0d: got %h required %h", k, encoded_data_out, exp_blk);
        end
      end
      n_checks++;
      if (block_lock !== (k >= 126)) begin
        n_fail++;
        $display("[TB] FAIL gap_lock cyc %0d: lock=%b required %b", k, block_lock, (k >= 126));
      end
      if (k == 126) exp_lock = 1'b1;
    end
  endtask

  task automatic test_reset_midlock();
    drive(2'b01, rand64(), 1'b1);
    @(posedge clk); #1;
    exp_blk = exp_q.pop_front();
    n_checks++;
    if (encoded_valid_out !== 1'b1 || encoded_data_out !== exp_blk) begin
      n_fail++;
      $display("[TB] FAIL mid_pre: valid_out=%b data=%h required 1 %h", encoded_valid_out, encoded_data_out, exp_blk);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (block_lock !== 1'b0 || encoded_valid_out !== 1'b0 || encoded_data_out !== 66'd0) begin
      n_fail++;
      $display("[TB] FAIL mid_async: lock=%b valid_out=%b data=%h required 0 0 0",
               block_lock, encoded_valid_out, encoded_data_out);
    end
    @(negedge clk);
    rst = 1'b1;
    rx_valid_in = 1'b0;
    exp_lock = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_descrambler();
    test_misaligned();
    test_tolerance();
    test_gapped();
    test_reset_midlock();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_block_sync.md
# rx_block_sync

Receive-side 64b/66b block synchronizer and self-synchronizing descrambler, placed directly upstream of `decoder`. It takes raw 66-bit blocks from the RX gearbox and hunts for sync-header alignment, asking the gearbox to slip by one bit when alignment is wrong. Once aligned, it descrambles the 64-bit payload (polynomial 1 + x^39 + x^58) and drives `decoder`'s `encoded_data_in` / `encoded_valid_in` with locked blocks only.

## Interface
- `PCS_DATA_WIDTH`, 66, block width. Bits [65:64] are the sync header; bits [63:0] are the payload, bit 0 first on the wire.
- `LOCK_CNT`, 64, consecutive valid headers needed to declare lock; also the length of the monitoring window.
- `BAD_SH_MAX`, 16, invalid headers within one window that force loss of lock.
- `SLIP_WAIT`, 4, valid input blocks ignored after a slip request.
- Ports (clock and reset first; one clock; reset is asynchronous and active-low):
- `clk`  in  1  single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `rx_data_in`  in  66  raw block from the gearbox.
- `rx_valid_in`  in  1  `rx_data_in` is valid this cycle.
- `encoded_data_out`  out  66  {header, descrambled payload}; connects to decoder `encoded_data_in`.
- `encoded_valid_out`  out  1  connects to decoder `encoded_valid_in`.
- `slip_out`  out  1  one-cycle pulse asking the gearbox to shift alignment by one bit.
- `block_lock`  out  1  high while aligned.

## Operation
- Header check, on valid input only:
  - 2'b01 (data) and 2'b10 (control) are valid.
  - 2'b00 and 2'b11 are invalid.
- Counters:
  - `sh_cnt` counts 0..LOCK_CNT.
  - `bad_cnt` counts 0..BAD_SH_MAX.
  - Both advance only on cycles with `rx_valid_in`=1.
- State machine (states RESET_CNT, TEST_SH, SLIP, SLIP_WAIT):
  - RESET_CNT: clear both counters, then go to TEST_SH on the next cycle. Input is not sampled in this cycle.
  - TEST_SH, unlocked:
    - Any invalid header → SLIP.
    - `sh_cnt` reaches LOCK_CNT → set `block_lock`=1, go to RESET_CNT.
  - TEST_SH, locked:
    - Every header increments `sh_cnt`; invalid headers also increment `bad_cnt`.
    - `bad_cnt` reaches BAD_SH_MAX → clear `block_lock`, go to SLIP. This takes priority over window end.
    - `sh_cnt` reaches LOCK_CNT with `bad_cnt` < BAD_SH_MAX → RESET_CNT, lock kept.
  - SLIP: `slip_out`=1 for exactly one cycle, `block_lock`=0, then SLIP_WAIT.
  - SLIP_WAIT: discard SLIP_WAIT valid blocks, then RESET_CNT.
- Descrambler:
  - State `s[57:0]` holds the last 58 received scrambled bits; `s[0]` is the oldest.
  - Let x = {`rx_data_in[63:0]`, s}.
  - Output bit i = x[58+i] ^ x[19+i] ^ x[i].
  - Next state s = `rx_data_in[63:6]`.
  - Updates on every valid input, locked or not, so the descrambler is synchronized by the time lock is declared.
  - The header is passed through unchanged.
- Output forwarding:
  - `encoded_valid_out`=1 only for valid input blocks accepted while `block_lock`=1.
  - This includes blocks with invalid headers; the decoder is responsible for error-coding them.

## Timing
- Reset values: `encoded_data_out`=0, `encoded_valid_out`=0, `slip_out`=0, `block_lock`=0, state=RESET_CNT, counters=0, s=0.
- Latency: one cycle, registered.
  - A valid input at edge N appears on `encoded_data_out` / `encoded_valid_out` after edge N+1.
  - `encoded_valid_out` is high for one cycle per accepted block.
  - `encoded_data_out` holds its last value when `encoded_valid_out`=0.
- Lock timing:
  - `block_lock` rises in the cycle after the LOCK_CNT-th valid header.
  - That block itself is not forwarded.
  - The first forwarded block is the next valid input.
- Loss of lock:
  - `block_lock` falls, and `slip_out` pulses, in the cycle after the BAD_SH_MAX-th invalid header.
  - The block carrying that header is still forwarded.
- No backpressure: the decoder has no input ready. `rx_valid_in` gaps simply stall the counters.
- Reset asserted mid-operation forces all reset values asynchronously. After deassertion, the search restarts from RESET_CNT.

## Test plan
- Reset: hold `rst`=0 with random input → all outputs 0. Release, then feed 63 blocks with header 2'b01 → `block_lock` stays 0. The 64th block → `block_lock`=1 on the next cycle, `encoded_valid_out` still 0 for that block.
- Misaligned stream:
  - Stimulus: header 2'b11 on the first block.
  - Required response: `slip_out` pulses exactly one cycle, followed by 4 ignored blocks.
  - Follow-on: after 64 good headers, lock is declared.
- Descrambler: scramble payload 64'h0000_0000_0000_0000 then idle blocks 66'h2_1E00_0000_0000_0000 with a reference model, seed 58'h3FF_FFFF_FFFF_FFFF → after lock, outputs equal the unscrambled originals (66'h21E00000000000000), one cycle after input.
- Locked tolerance:
  - Stimulus: 15 invalid headers in one 64-block window.
  - Required response: lock holds and all 64 blocks are forwarded.
  - Follow-on: 16 invalid headers in the next window → `block_lock` falls and `slip_out` pulses after the 16th.
- Gapped valid: toggle `rx_valid_in` 1/0 every cycle during acquisition → lock takes 64 valid blocks (128 cycles). Counters hold during gaps, and no output appears for invalid cycles.
- Reset mid-lock: assert `rst`=0 while locked with data flowing → `block_lock` and `encoded_valid_out` drop immediately, without waiting for a clock edge.
